// File: rtl/sram_pkg.sv
// Shared definitions for the single-port SRAM macro model.
//   DATA_WIDTH / ADDR_WIDTH : default word and address widths
//   data_t / addr_t         : word and address types at the default widths
//   CS_ACTIVE / WE_WRITE    : active levels of the chip-select and write-enable strobes
package sram_pkg;

  localparam int unsigned DATA_WIDTH = 2;
  localparam int unsigned ADDR_WIDTH = 4;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  // Both strobes are active low.
  localparam logic CS_ACTIVE = 1'b0;
  localparam logic WE_WRITE  = 1'b0;

endpackage : sram_pkg

// File: rtl/sram_array.sv
// Flop-based storage array: one synchronous write port, one asynchronous read index,
// and an asynchronous clear of every word on reset.
//   clk   : write clock (rising edge)
//   rst   : asynchronous active-high clear of all words
//   we    : write strobe, active high, sampled on the rising edge
//   waddr : write word address
//   wdata : write data
//   raddr : read word address
//   rdata : combinational read of mem[raddr]
module sram_array #(
  parameter int unsigned DATA_WIDTH = 2,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage words; reset clears the whole array at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : sram_array

// File: rtl/sram_2x16_scn4m_subm.sv
// Single-port synchronous SRAM model (16 x 2 by default) standing in for the
// scn4m_subm hard macro. Control decode and the registered read port live here;
// storage lives in sram_array.
//   clk0  : port clock, all inputs sampled on the rising edge
//   rst0  : asynchronous active-high reset, clears dout0 and every word
//   csb0  : chip select, active low
//   web0  : write enable, active low (0 = write, 1 = read) when selected
//   addr0 : word address
//   din0  : write data
//   dout0 : registered read data, updated only by read cycles
module sram_2x16_scn4m_subm #(
  parameter int unsigned DATA_WIDTH = 2,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0
);

  import sram_pkg::*;

  logic                  wr_en_c;
  logic                  rd_en_c;
  logic [DATA_WIDTH-1:0] rdata;

  // Strobe decode. Equality tests are deliberate: an unknown csb0/web0 makes the
  // condition non-true, so neither the array nor dout0 is touched.
  always_comb begin
    wr_en_c = 1'b0;
    rd_en_c = 1'b0;
    if (csb0 == CS_ACTIVE) begin
      if (web0 == WE_WRITE) begin
        wr_en_c = 1'b1;
      end else if (web0 == ~WE_WRITE) begin
        rd_en_c = 1'b1;
      end
    end
  end

  sram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .clk   (clk0),
    .rst   (rst0),
    .we    (wr_en_c),
    .waddr (addr0),
    .wdata (din0),
    .raddr (addr0),
    .rdata (rdata)
  );

  // Read data register; writes and idle cycles leave it unchanged (no write-through).
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      dout0 <= '0;
    end else if (rd_en_c) begin
      dout0 <= rdata;
    end
  end

endmodule : sram_2x16_scn4m_subm

// File: tb/tb_sram_2x16_scn4m_subm.sv
// Self-checking bench for sram_2x16_scn4m_subm: directed scenarios plus a random
// access stream checked against an array-based model of the memory.
module tb_sram_2x16_scn4m_subm;

  import sram_pkg::*;

  logic  clk0;
  logic  rst0;
  logic  csb0;
  logic  web0;
  addr_t addr0;
  data_t din0;
  data_t dout0;

  int checks;
  int errors;

  // Reference model: word contents and the value dout0 must currently show.
  data_t model_mem [16];
  data_t exp_dout;

  sram_2x16_scn4m_subm #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (16)
  ) dut (
    .clk0  (clk0),
    .rst0  (rst0),
    .csb0  (csb0),
    .web0  (web0),
    .addr0 (addr0),
    .din0  (din0),
    .dout0 (dout0)
  );

  initial begin
    clk0 = 1'b0;
    forever #5 clk0 = ~clk0;
  end

  task automatic model_clear();
    for (int i = 0; i < 16; i++) model_mem[i] = '0;
    exp_dout = '0;
  endtask

  // Apply one access: inputs change mid-cycle, model updates after the rising edge.
  task automatic step(input logic csb, input logic web, input addr_t a, input data_t d);
    @(negedge clk0);
    csb0  = csb;
    web0  = web;
    addr0 = a;
    din0  = d;
    @(posedge clk0);
    #1;
    if (!rst0 && !csb) begin
      if (!web) model_mem[a] = d;
      else      exp_dout = model_mem[a];
    end
  endtask

  task automatic test_reset();
    csb0 = 1'b1; web0 = 1'b1; addr0 = '0; din0 = '0;
    rst0 = 1'b0;
    #1 rst0 = 1'b1;
    #1;
    model_clear();
    checks++;
    if (dout0 !== 2'd0) begin
      errors++;
      $display("FAIL reset_dout got=%0d exp=0", dout0);
    end
    repeat (2) @(posedge clk0);
    @(negedge clk0);
    rst0 = 1'b0;
    step(1'b0, 1'b1, 4'd5, 2'd0);
    checks++;
    if (dout0 !== 2'd0) begin
      errors++;
      $display("FAIL reset_read5 got=%0d exp=0", dout0);
    end
  endtask

  task automatic test_sweep();
    int wa [16] = '{3, 6, 8, 2, 5, 12, 0, 15, 11, 14, 4, 1, 13, 10, 9, 7};
    int wd [16] = '{1, 3, 2, 1, 3, 3, 0, 3, 3, 2, 0, 0, 3, 3, 0, 0};
    int ra [16] = '{6, 0, 7, 10, 3, 12, 14, 11, 9, 15, 4, 1, 8, 13, 5, 2};
    int rd [16] = '{3, 0, 0, 3, 1, 3, 2, 3, 0, 3, 0, 0, 2, 3, 3, 1};
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 4'(wa[i]), 2'(wd[i]));
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 4'(ra[i]), 2'd0);
      checks++;
      if (dout0 !== 2'(rd[i])) begin
        errors++;
        $display("FAIL sweep_read addr=%0d got=%0d exp=%0d", ra[i], dout0, rd[i]);
      end
    end
  endtask

  task automatic test_write_hold();
    step(1'b0, 1'b1, 4'd6, 2'd0);
    checks++;
    if (dout0 !== 2'd3) begin
      errors++;
      $display("FAIL hold_pre_read got=%0d exp=3", dout0);
    end
    step(1'b0, 1'b0, 4'd6, 2'd0);
    checks++;
    if (dout0 !== 2'd3) begin
      errors++;
      $display("FAIL hold_during_write got=%0d exp=3", dout0);
    end
    step(1'b0, 1'b1, 4'd6, 2'd0);
    checks++;
    if (dout0 !== 2'd0) begin
      errors++;
      $display("FAIL hold_post_read got=%0d exp=0", dout0);
    end
  endtask

  task automatic test_deselect();
    step(1'b0, 1'b1, 4'd13, 2'd0);
    step(1'b1, 1'b0, 4'd8, 2'd0);
    checks++;
    if (dout0 !== 2'd3) begin
      errors++;
      $display("FAIL deselect_dout got=%0d exp=3", dout0);
    end
    step(1'b0, 1'b1, 4'd8, 2'd0);
    checks++;
    if (dout0 !== 2'd2) begin
      errors++;
      $display("FAIL deselect_read8 got=%0d exp=2", dout0);
    end
  endtask

  task automatic test_back_to_back();
    step(1'b0, 1'b0, 4'd15, 2'd1);
    step(1'b0, 1'b1, 4'd15, 2'd0);
    checks++;
    if (dout0 !== 2'd1) begin
      errors++;
      $display("FAIL wr_then_rd got=%0d exp=1", dout0);
    end
  endtask

  task automatic test_random();
    logic  csb, web;
    addr_t a;
    data_t d;
    for (int i = 0; i < 300; i++) begin
      csb = ($urandom_range(0, 4) == 0);
      web = $urandom_range(0, 1) == 1;
      a   = 4'($urandom_range(0, 15));
      d   = 2'($urandom_range(0, 3));
      step(csb, web, a, d);
      checks++;
      if (dout0 !== exp_dout) begin
        errors++;
        $display("FAIL random i=%0d csb=%0b web=%0b addr=%0d got=%0d exp=%0d",
                 i, csb, web, a, dout0, exp_dout);
      end
    end
    // Final readback of every word against the model.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 4'(i), 2'd0);
      checks++;
      if (dout0 !== model_mem[i]) begin
        errors++;
        $display("FAIL random_readback addr=%0d got=%0d exp=%0d", i, dout0, model_mem[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b0, 4'd5, 2'd3);
    step(1'b0, 1'b1, 4'd5, 2'd0);
    checks++;
    if (dout0 !== 2'd3) begin
      errors++;
      $display("FAIL reset_mid_pre got=%0d exp=3", dout0);
    end
    // Assert reset between edges; dout0 must clear without waiting for a clock.
    @(negedge clk0);
    #2 rst0 = 1'b1;
    #1;
    model_clear();
    checks++;
    if (dout0 !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid_async got=%0d exp=0", dout0);
    end
    // A write attempted while reset is held must be ignored.
    csb0 = 1'b0; web0 = 1'b0; addr0 = 4'd5; din0 = 2'd3;
    repeat (2) @(posedge clk0);
    @(negedge clk0);
    csb0 = 1'b1;
    rst0 = 1'b0;
    step(1'b0, 1'b1, 4'd5, 2'd0);
    checks++;
    if (dout0 !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid_read5 got=%0d exp=0", dout0);
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 4'(i), 2'd0);
      checks++;
      if (dout0 !== 2'd0) begin
        errors++;
        $display("FAIL reset_mid_cleared addr=%0d got=%0d exp=0", i, dout0);
      end
    end
    // First access after release is honoured.
    step(1'b0, 1'b0, 4'd9, 2'd2);
    step(1'b0, 1'b1, 4'd9, 2'd0);
    checks++;
    if (dout0 !== 2'd2) begin
      errors++;
      $display("FAIL reset_mid_rewrite got=%0d exp=2", dout0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_sweep();
    test_write_hold();
    test_deselect();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sram_2x16_scn4m_subm
